gemm_tile_sched: RTL

Sequencer that computes one full M_TILE x N_TILE output tile on a single gemm_core.
- For each output element it pulses the core's cfg_start.
- It fetches K_TILE operand pairs from the A and B tile buffers (synchronous read, 1-cycle latency) and streams them into the core with valid/ready.
- It forwards each core result to a tagged result stream in row-major order.
- It sits between the tile DMA/buffers and the gemm_core; a host-side command block pulses start.

---
 rtl/gemm_pkg.sv | 24 ++
 rtl/gemm_operand_skid.sv | 50 +++++
 rtl/gemm_tile_sched.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// Shared types and default tile geometry for the GEMM tile scheduler slice.
package gemm_pkg;

    localparam int M_TILE    = 4;
    localparam int N_TILE    = 8;
    localparam int K_TILE    = 16;
    localparam int A_WIDTH   = 16;
    localparam int B_WIDTH   = 8;
    localparam int ACC_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } sched_state_t;

    // Index width that never collapses to zero bits for a bound of 1.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gemm_operand_skid.sv
// Two-entry fall-through FIFO for {a,b} operand pairs; a push into an empty FIFO is visible the same cycle.
module gemm_operand_skid #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    import gemm_pkg::*;

    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             bypass;
    logic             wr_en;
    logic             rd_en;

    // Pair arriving into an empty FIFO and consumed immediately never gets stored.
    assign bypass    = (count_reg == 2'd0) && push && pop;
    assign wr_en     = push && !bypass;
    assign rd_en     = pop && !bypass;
    assign out_valid = (count_reg != 2'd0) || push;
    assign out_data  = (count_reg == 2'd0) ? push_data : mem_reg[rd_ptr_reg];
    assign count     = count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            mem_reg[0] <= '0;
            mem_reg[1] <= '0;
        end else begin
            if (wr_en) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (rd_en)
                rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end

endmodule

// File: rtl/gemm_tile_sched.sv
// Walks one M_TILE x N_TILE output tile on a single gemm_core: launch, feed K_TILE operand pairs, drain result.
module gemm_tile_sched #(
    parameter int M_TILE    = gemm_pkg::M_TILE,
    parameter int N_TILE    = gemm_pkg::N_TILE,
    parameter int K_TILE    = gemm_pkg::K_TILE,
    parameter int A_WIDTH   = gemm_pkg::A_WIDTH,
    parameter int B_WIDTH   = gemm_pkg::B_WIDTH,
    parameter int ACC_WIDTH = gemm_pkg::ACC_WIDTH,
    parameter int AA_W      = gemm_pkg::idx_w(M_TILE * K_TILE),
    parameter int BA_W      = gemm_pkg::idx_w(K_TILE * N_TILE)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  a_rd_en,
    output logic [AA_W-1:0]                       a_rd_addr,
    input  logic [A_WIDTH-1:0]                    a_rd_data,
    output logic                                  b_rd_en,
    output logic [BA_W-1:0]                       b_rd_addr,
    input  logic [B_WIDTH-1:0]                    b_rd_data,
    output logic                                  core_start,
    output logic                                  core_in_valid,
    input  logic                                  core_in_ready,
    output logic [A_WIDTH-1:0]                    core_a,
    output logic [B_WIDTH-1:0]                    core_b,
    input  logic                                  core_out_valid,
    output logic                                  core_out_ready,
    input  logic [ACC_WIDTH-1:0]                  core_out_data,
    output logic                                  res_valid,
    input  logic                                  res_ready,
    output logic [ACC_WIDTH-1:0]                  res_data,
    output logic [gemm_pkg::idx_w(M_TILE)-1:0]    res_row,
    output logic [gemm_pkg::idx_w(N_TILE)-1:0]    res_col,
    output logic                                  res_last
);
    import gemm_pkg::*;

    localparam int MW = idx_w(M_TILE);
    localparam int NW = idx_w(N_TILE);
    localparam int KW = $clog2(K_TILE + 1);
    localparam int PW = A_WIDTH + B_WIDTH;

    sched_state_t   state_reg, state_next;
    logic [MW-1:0]  m_reg;
    logic [NW-1:0]  n_reg;
    logic [KW-1:0]  k_issue_reg;
    logic [KW-1:0]  k_sent_reg;
    logic           pending_reg;

    logic           fifo_valid;
    logic [PW-1:0]  fifo_head;
    logic [1:0]     fifo_count;
    logic [2:0]     inflight;
    logic           in_fire;
    logic           res_fire;
    logic           rd_issue;
    logic           in_drain;
    logic           last_elem;
    logic [AA_W-1:0] a_addr;
    logic [BA_W-1:0] b_addr;

    gemm_operand_skid #(.WIDTH(PW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pending_reg),
        .push_data ({a_rd_data, b_rd_data}),
        .pop       (in_fire),
        .out_valid (fifo_valid),
        .out_data  (fifo_head),
        .count     (fifo_count)
    );

    assign in_drain  = (state_reg == S_DRAIN);
    assign last_elem = (m_reg == MW'(M_TILE - 1)) && (n_reg == NW'(N_TILE - 1));

    assign core_in_valid = (state_reg == S_FEED) && fifo_valid;
    assign in_fire       = core_in_valid && core_in_ready;

    // Stored + in-flight pairs after this cycle's pop must leave room for one more read.
    assign inflight = {1'b0, fifo_count} + {2'b00, pending_reg} - {2'b00, in_fire};
    assign rd_issue = ((state_reg == S_LAUNCH) || (state_reg == S_FEED))
                      && (k_issue_reg < KW'(K_TILE)) && (inflight < 3'd2);

    assign a_addr = AA_W'(int'(m_reg) * K_TILE + int'(k_issue_reg));
    assign b_addr = BA_W'(int'(k_issue_reg) * N_TILE + int'(n_reg));

    assign a_rd_en   = rd_issue;
    assign b_rd_en   = rd_issue;
    assign a_rd_addr = rd_issue ? a_addr : '0;
    assign b_rd_addr = rd_issue ? b_addr : '0;

    assign core_start = (state_reg == S_LAUNCH);
    assign core_a     = core_in_valid ? fifo_head[PW-1:B_WIDTH] : '0;
    assign core_b     = core_in_valid ? fifo_head[B_WIDTH-1:0]  : '0;

    // Result path is a pure pass-through so the core itself holds data under backpressure.
    assign res_valid      = in_drain && core_out_valid;
    assign core_out_ready = in_drain && res_ready;
    assign res_fire       = res_valid && res_ready;
    assign res_data       = in_drain ? core_out_data : '0;
    assign res_row        = in_drain ? m_reg : '0;
    assign res_col        = in_drain ? n_reg : '0;
    assign res_last       = in_drain && last_elem;

    assign busy = (state_reg == S_LAUNCH) || (state_reg == S_FEED) || in_drain;
    assign done = (state_reg == S_DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_LAUNCH;
            S_LAUNCH: state_next = S_FEED;
            S_FEED:   if (in_fire && (k_sent_reg == KW'(K_TILE - 1))) state_next = S_DRAIN;
            S_DRAIN:  if (res_fire) state_next = last_elem ? S_DONE : S_LAUNCH;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            m_reg       <= '0;
            n_reg       <= '0;
            k_issue_reg <= '0;
            k_sent_reg  <= '0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= rd_issue;
            if ((state_reg == S_IDLE) && start) begin
                m_reg <= '0;
                n_reg <= '0;
            end
            if (state_next == S_LAUNCH) begin
                k_issue_reg <= '0;
                k_sent_reg  <= '0;
            end else begin
                if (rd_issue) k_issue_reg <= k_issue_reg + 1'b1;
                if (in_fire)  k_sent_reg  <= k_sent_reg + 1'b1;
            end
            if (res_fire) begin
                if (n_reg == NW'(N_TILE - 1)) begin
                    n_reg <= '0;
                    m_reg <= (m_reg == MW'(M_TILE - 1)) ? '0 : m_reg + 1'b1;
                end else begin
                    n_reg <= n_reg + 1'b1;
                end
            end
        end
    end

endmodule
